parity_gen_stream: RTL and testbench

- Parametrised, registered successor to the team's 3-input XOR parity generator.
- Accepts a valid/ready stream of WIDTH-bit words grouped into frames, and passes each word through with one cycle of latency.
- Appends two bits to every word:
  - the parity bit for that word;
  - on the last beat of a frame, the accumulated parity bit for the whole frame and the frame length.
- Sits between a word source and a serialiser/link layer. Even or odd parity is selectable per frame.

---
 rtl/parity_gen_stream_pkg.sv | 10 +
 rtl/parity_gen_stream_if.sv | 33 +++
 rtl/parity_gen_stream_tree.sv | 11 +
 rtl/parity_gen_stream.sv | 124 ++++++++++++
 tb/tb_parity_gen_stream.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/parity_gen_stream_pkg.sv
// Shared constants for the parity stream block: parity mode encodings and default sizes.
package parity_gen_stream_pkg;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/parity_gen_stream_if.sv
// Word stream in, parity-annotated word stream out; slave is the block's view, master the source/sink's view.
interface parity_gen_stream_if
   import parity_gen_stream_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
);
   logic             mode_odd;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic             out_word_par;
   logic             out_frame_par;
   logic [CNT_W-1:0] out_frame_len;
   logic             out_len_sat;

   modport slave (
      input  mode_odd, in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, out_word_par,
             out_frame_par, out_frame_len, out_len_sat
   );

   modport master (
      output mode_odd, in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_word_par,
             out_frame_par, out_frame_len, out_len_sat
   );
endinterface

// File: rtl/parity_gen_stream_tree.sv
// Combinational XOR reduction of one data word.
module parity_tree
   import parity_gen_stream_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] data_i,
   output logic             p_o
);
   assign p_o = ^data_i;
endmodule

// File: rtl/parity_gen_stream.sv
// Registered pass-through of a framed word stream adding word parity, and on the last beat frame parity and length.
// One cycle latency; full throughput, in_ready = !out_valid || out_ready.
module parity_gen_stream
   import parity_gen_stream_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   parity_gen_stream_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             out_vld_q, out_vld_d;
   logic [WIDTH-1:0] out_dat_q, out_dat_d;
   logic             out_last_q, out_last_d;
   logic             wpar_q, wpar_d;
   logic             fpar_q, fpar_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic             lsat_q, lsat_d;
   logic             acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;
   logic             in_frame_q, in_frame_d;
   logic             mode_q, mode_d;

   logic p;
   logic in_rdy;
   logic accept;
   logic m;
   logic cnt_full;

   parity_tree #(.WIDTH(WIDTH)) u_tree (
      .data_i (bus.in_data),
      .p_o    (p)
   );

   assign in_rdy   = !out_vld_q || bus.out_ready;
   assign accept   = bus.in_valid && in_rdy;
   // First beat of a frame takes the live mode; later beats use the latched one
   assign m        = in_frame_q ? mode_q : bus.mode_odd;
   assign cnt_full = (cnt_q == CNT_MAX);

   always_comb begin
      out_vld_d  = out_vld_q;
      out_dat_d  = out_dat_q;
      out_last_d = out_last_q;
      wpar_d     = wpar_q;
      fpar_d     = fpar_q;
      len_d      = len_q;
      lsat_d     = lsat_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      sat_d      = sat_q;
      in_frame_d = in_frame_q;
      mode_d     = mode_q;
      if (accept) begin
         out_vld_d  = 1'b1;
         out_dat_d  = bus.in_data;
         out_last_d = bus.in_last;
         wpar_d     = p ^ m;
         if (bus.in_last) begin
            fpar_d     = acc_q ^ p ^ m;
            len_d      = cnt_full ? CNT_MAX : cnt_q + 1'b1;
            lsat_d     = sat_q | cnt_full;
            acc_d      = 1'b0;
            cnt_d      = '0;
            sat_d      = 1'b0;
            in_frame_d = 1'b0;
         end else begin
            fpar_d     = 1'b0;
            len_d      = '0;
            lsat_d     = 1'b0;
            acc_d      = acc_q ^ p;
            if (cnt_full) sat_d = 1'b1;
            else          cnt_d = cnt_q + 1'b1;
            in_frame_d = 1'b1;
            mode_d     = m;
         end
      end else if (bus.out_ready) begin
         out_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld_q  <= 1'b0;
         out_dat_q  <= '0;
         out_last_q <= 1'b0;
         wpar_q     <= 1'b0;
         fpar_q     <= 1'b0;
         len_q      <= '0;
         lsat_q     <= 1'b0;
         acc_q      <= 1'b0;
         cnt_q      <= '0;
         sat_q      <= 1'b0;
         in_frame_q <= 1'b0;
         mode_q     <= PAR_EVEN;
      end else begin
         out_vld_q  <= out_vld_d;
         out_dat_q  <= out_dat_d;
         out_last_q <= out_last_d;
         wpar_q     <= wpar_d;
         fpar_q     <= fpar_d;
         len_q      <= len_d;
         lsat_q     <= lsat_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         sat_q      <= sat_d;
         in_frame_q <= in_frame_d;
         mode_q     <= mode_d;
      end
   end

   assign bus.in_ready      = in_rdy;
   assign bus.out_valid     = out_vld_q;
   assign bus.out_data      = out_dat_q;
   assign bus.out_last      = out_last_q;
   assign bus.out_word_par  = wpar_q;
   assign bus.out_frame_par = fpar_q;
   assign bus.out_frame_len = len_q;
   assign bus.out_len_sat   = lsat_q;
endmodule

// File: tb/tb_parity_gen_stream.sv
// Bench for parity_gen_stream: a default-size instance and a CNT_W=2 instance share one input stream.
module tb_parity_gen_stream;
   import parity_gen_stream_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   parity_gen_stream_if #(.WIDTH(8), .CNT_W(8)) bus ();
   parity_gen_stream_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

   assign bus2.mode_odd  = bus.mode_odd;
   assign bus2.in_valid  = bus.in_valid;
   assign bus2.in_data   = bus.in_data;
   assign bus2.in_last   = bus.in_last;
   assign bus2.out_ready = bus.out_ready;

   parity_gen_stream #(.WIDTH(8), .CNT_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
   parity_gen_stream #(.WIDTH(8), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   int errors = 0;
   int checks = 0;

   logic [20:0] obs1;
   logic [17:0] obs2;
   assign obs1 = {bus.out_valid, bus.out_data, bus.out_last, bus.out_word_par,
                  bus.out_frame_par, bus.out_frame_len, bus.out_len_sat};
   assign obs2 = {bus2.out_valid, bus2.out_data, bus2.out_last, bus2.out_word_par,
                  bus2.out_frame_par, bus2.out_frame_len, bus2.out_len_sat};

   // Reference model: expected output beats, frame tracked as beat count and ones count
   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       wpar;
      logic       fpar;
      logic [7:0] len8;
      logic       sat8;
      logic [1:0] len2;
      logic       sat2;
   } exp_t;

   exp_t q[$];
   bit   m_in_frame, m_mode, md, emit_m, acc_m;
   int   m_n, m_ones;
   exp_t e_m;

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         m_in_frame = 0; m_mode = 0; m_n = 0; m_ones = 0;
      end else begin
         emit_m = (q.size() > 0) && bus.out_ready;
         acc_m  = bus.in_valid && ((q.size() == 0) || bus.out_ready);
         if (emit_m) void'(q.pop_front());
         if (acc_m) begin
            md = m_in_frame ? m_mode : bus.mode_odd;
            m_n++;
            m_ones += $countones(bus.in_data);
            e_m.data = bus.in_data;
            e_m.last = bus.in_last;
            e_m.wpar = ($countones(bus.in_data) % 2 == 1) ^ md;
            if (bus.in_last) begin
               e_m.fpar = (m_ones % 2 == 1) ^ md;
               e_m.len8 = 8'((m_n > 255) ? 255 : m_n);
               e_m.sat8 = (m_n > 255);
               e_m.len2 = 2'((m_n > 3) ? 3 : m_n);
               e_m.sat2 = (m_n > 3);
               m_in_frame = 0; m_n = 0; m_ones = 0;
            end else begin
               e_m.fpar = 0; e_m.len8 = 0; e_m.sat8 = 0; e_m.len2 = 0; e_m.sat2 = 0;
               m_in_frame = 1;
               m_mode = md;
            end
            q.push_back(e_m);
         end
      end
   end

   task automatic tick(input logic v, input logic [7:0] d, input logic l,
                       input logic mo, input logic ordy);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.in_last   = l;
      bus.mode_odd  = mo;
      bus.out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
         checks++;
         if (obs1 !== 21'd0) begin
            errors++; $display("FAIL reset_out: got %h expected %h", obs1, 21'd0);
         end
         checks++;
         if (obs2 !== 18'd0) begin
            errors++; $display("FAIL reset_out_sat: got %h expected %h", obs2, 18'd0);
         end
      end
      rst = 1'b0;
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_no_accept: got %b expected 0", bus.out_valid);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      end
   endtask

   task automatic test_single(input logic [7:0] d, input logic mo,
                              input logic wexp, input logic fexp);
      tick(1'b1, d, 1'b1, mo, 1'b1);
      checks++;
      if (obs1 !== {1'b1, d, 1'b1, wexp, fexp, 8'd1, 1'b0}) begin
         errors++; $display("FAIL single_%h: got %h expected %h", d, obs1,
                            {1'b1, d, 1'b1, wexp, fexp, 8'd1, 1'b0});
      end
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL single_drain: got %b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_three_beat(input logic mo_first, input logic [2:0] wexp,
                                  input logic fexp);
      logic [7:0] dv [3];
      dv[0] = 8'h01; dv[1] = 8'h03; dv[2] = 8'h80;
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, dv[i], i == 2, (i == 0) ? mo_first : 1'b0, 1'b1);
         checks++;
         if ({bus.out_valid, bus.out_data, bus.out_word_par} !== {1'b1, dv[i], wexp[2-i]}) begin
            errors++; $display("FAIL three_beat_%0d: got v=%b d=%h wp=%b expected v=1 d=%h wp=%b",
                               i, bus.out_valid, bus.out_data, bus.out_word_par, dv[i], wexp[2-i]);
         end
      end
      checks++;
      if ({bus.out_last, bus.out_frame_par, bus.out_frame_len} !== {1'b1, fexp, 8'd3}) begin
         errors++; $display("FAIL three_beat_frame: got last=%b fp=%b len=%0d expected last=1 fp=%b len=3",
                            bus.out_last, bus.out_frame_par, bus.out_frame_len, fexp);
      end
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_backpressure();
      logic [20:0] held;
      held = {1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
      tick(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
         checks++;
         if (obs1 !== held) begin
            errors++; $display("FAIL bp_hold_%0d: got %h expected %h", i, obs1, held);
         end
         checks++;
         if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_in_ready_%0d: got %b expected 0", i, bus.in_ready);
         end
      end
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready);
      end
      tick(1'b1, 8'hC3, 1'b1, 1'b1, 1'b1);
      checks++;
      if (obs1 !== {1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0}) begin
         errors++; $display("FAIL bp_next_beat: got %h expected %h", obs1,
                            {1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0});
      end
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_no_duplicate: got %b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_reset_midframe();
      tick(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
      tick(1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      tick(1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
      checks++;
      if (obs1 !== {1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0}) begin
         errors++; $display("FAIL midframe_reset: got %h expected %h", obs1,
                            {1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0});
      end
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_saturation();
      for (int n = 3; n <= 5; n++) begin
         for (int i = 0; i < n; i++)
            tick(1'b1, 8'(1 << i), i == n - 1, 1'b0, 1'b1);
         checks++;
         if ({bus.out_frame_par, bus.out_frame_len, bus.out_len_sat} !== {1'(n % 2), 8'(n), 1'b0}) begin
            errors++; $display("FAIL sat_wide_%0d: got fp=%b len=%0d sat=%b expected fp=%0d len=%0d sat=0",
                               n, bus.out_frame_par, bus.out_frame_len, bus.out_len_sat, n % 2, n);
         end
         checks++;
         if ({bus2.out_frame_len, bus2.out_len_sat} !== {2'((n > 3) ? 3 : n), 1'(n > 3)}) begin
            errors++; $display("FAIL sat_narrow_%0d: got len=%0d sat=%b expected len=%0d sat=%0d",
                               n, bus2.out_frame_len, bus2.out_len_sat, (n > 3) ? 3 : n, n > 3);
         end
      end
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      logic [20:0] exp1;
      logic [17:0] exp2;
      for (int c = 0; c < 600; c++) begin
         tick($urandom_range(3, 0) != 0, 8'($urandom), $urandom_range(4, 0) == 0,
              1'($urandom), $urandom_range(2, 0) != 0);
         checks++;
         if (bus.in_ready !== ((q.size() == 0) || bus.out_ready)) begin
            errors++; $display("FAIL rand_in_ready_%0d: got %b expected %b", c, bus.in_ready,
                               (q.size() == 0) || bus.out_ready);
         end
         if (q.size() == 0) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin
               errors++; $display("FAIL rand_valid_%0d: got %b expected 0", c, bus.out_valid);
            end
         end else begin
            exp1 = {1'b1, q[0].data, q[0].last, q[0].wpar, q[0].fpar, q[0].len8, q[0].sat8};
            exp2 = {1'b1, q[0].data, q[0].last, q[0].wpar, q[0].fpar, q[0].len2, q[0].sat2};
            checks++;
            if (obs1 !== exp1) begin
               errors++; $display("FAIL rand_beat_%0d: got %h expected %h", c, obs1, exp1);
            end
            checks++;
            if (obs2 !== exp2) begin
               errors++; $display("FAIL rand_beat_sat_%0d: got %h expected %h", c, obs2, exp2);
            end
         end
      end
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.in_last   = 1'b0;
      bus.mode_odd  = 1'b0;
      bus.out_ready = 1'b1;
      test_reset();
      test_single(8'hA5, 1'b0, 1'b0, 1'b0);
      test_single(8'h07, 1'b1, 1'b0, 1'b0);
      test_three_beat(1'b0, 3'b101, 1'b0);
      test_three_beat(1'b1, 3'b010, 1'b1);
      test_backpressure();
      test_reset_midframe();
      test_saturation();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
